alu2_issue_seq: RTL

Sequential issue/capture stage wrapped around the 10-input/6-output combinational ALU core. Commands arrive on a valid/ready port and are buffered in a small FIFO. The head command is presented to the core's `pi9..pi0` inputs, and the core's `po5..po0` outputs are registered into a result slot with its own valid/ready port. The block turns the purely combinational ALU into a throttled, one-result-per-cycle pipeline stage.

---
 rtl/alu2_issue_pkg.sv | 35 +++
 rtl/alu2_issue_seq_if.sv | 48 ++++
 rtl/alu2_cmd_fifo.sv | 57 +++++
 rtl/alu2_issue_seq.sv | 93 +++++++++
 4 files changed

// File: rtl/alu2_issue_pkg.sv
// ============================================================================
//  Module   : alu2_issue_pkg
//  Brief    : Shared widths, types and the derived-state helper for alu2_issue_seq.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu2_issue_pkg;

    localparam int ALU2_IN_W  = 10;
    localparam int ALU2_OUT_W = 6;
    localparam int ALU2_TAG_W = 4;

    typedef logic [ALU2_IN_W-1:0]  alu2_cmd_t;
    typedef logic [ALU2_OUT_W-1:0] alu2_res_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RUN     = 2'd2,
        ST_BLOCKED = 2'd3
    } alu2_state_t;

    // Pure decode of occupancy and result-slot handshake; no storage behind it.
    function automatic alu2_state_t alu2_state_f(input logic nonempty,
                                                 input logic res_valid,
                                                 input logic res_ready);
        if (!nonempty)
            return res_valid ? ST_DRAIN : ST_EMPTY;
        return (res_valid && !res_ready) ? ST_BLOCKED : ST_RUN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu2_issue_seq_if.sv
// ============================================================================
//  Module   : alu2_issue_seq_if
//  Brief    : Command/result handshake bundle; res_tag exists only when
//             ALU2_ISSUE_TAG_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu2_issue_seq_if
    import alu2_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = ALU2_IN_W,
    parameter int OUT_W = ALU2_OUT_W
);
    logic                     flush;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [IN_W-1:0]          cmd_data;
    logic                     res_valid;
    logic                     res_ready;
    logic [OUT_W-1:0]         res_data;
    logic [$clog2(DEPTH):0]   level;
    alu2_state_t              state;
`ifdef ALU2_ISSUE_TAG_EN
    logic [ALU2_TAG_W-1:0]    res_tag;

    modport master (
        output flush, cmd_valid, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, level, state, res_tag
    );
    modport slave (
        input  flush, cmd_valid, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, level, state, res_tag
    );
`else
    modport master (
        output flush, cmd_valid, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, level, state
    );
    modport slave (
        input  flush, cmd_valid, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, level, state
    );
`endif
endinterface

`default_nettype wire

// File: rtl/alu2_cmd_fifo.sv
// ============================================================================
//  Module   : alu2_cmd_fifo
//  Brief    : Power-of-two command FIFO with occupancy count and head output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu2_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [W-1:0]             wr_data,
    output logic      [W-1:0]             rd_data,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Pointers wrap naturally; the level counter tells full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (push && !pop)
                r_level <= r_level + LVL_W'(1);
            else if (!push && pop)
                r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

`default_nettype wire

// File: rtl/alu2_issue_seq.sv
// ============================================================================
//  Module   : alu2_issue_seq
//  Brief    : Issue/capture stage around the combinational ALU core; optional
//             result sequence tag enabled by ALU2_ISSUE_TAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu2_issue_seq
    import alu2_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = ALU2_IN_W,
    parameter int OUT_W = ALU2_OUT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu2_issue_seq_if.slave       bus,
    output logic [IN_W-1:0]       alu_pi,
    input  wire logic [OUT_W-1:0] alu_po
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [LVL_W-1:0] w_level;
    logic [IN_W-1:0]  w_head;
    logic             w_nonempty;
    logic             w_push;
    logic             w_issue;
    logic             r_res_valid;
    logic [OUT_W-1:0] r_res_data;

    assign w_nonempty    = (w_level != '0);
    assign bus.cmd_ready = (w_level != LVL_W'(DEPTH));
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_issue       = w_nonempty && (!r_res_valid || bus.res_ready);

    alu2_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (IN_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push    (w_push),
        .pop     (w_issue),
        .wr_data (bus.cmd_data),
        .rd_data (w_head),
        .level   (w_level)
    );

    // Quiet core input while empty keeps the core from toggling on stale data.
    assign alu_pi = w_nonempty ? w_head : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (bus.flush) begin
            r_res_valid <= 1'b0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_data  <= alu_po;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef ALU2_ISSUE_TAG_EN
    logic [ALU2_TAG_W-1:0] r_tag_cnt;
    logic [ALU2_TAG_W-1:0] r_res_tag;

    // Flush leaves the sequence running so tags stay unique across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_cnt <= '0;
            r_res_tag <= '0;
        end else if (w_issue && !bus.flush) begin
            r_res_tag <= r_tag_cnt;
            r_tag_cnt <= r_tag_cnt + ALU2_TAG_W'(1);
        end
    end

    assign bus.res_tag = r_res_tag;
`endif

    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.level     = w_level;
    assign bus.state     = alu2_state_f(w_nonempty, r_res_valid, bus.res_ready);

endmodule

`default_nettype wire
